// File: rtl/jkff_mon_pkg.sv
// Shared types and defaults for the JK flip-flop divergence monitor.
// The state encoding is visible on the STATE port, so the values are fixed.
package jkff_mon_pkg;

  typedef enum logic [1:0] {
    ST_MATCH   = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2
  } mon_state_e;

  localparam int RUN_W              = 8;
  localparam int DEF_CNT_W          = 8;
  localparam int DEF_MISMATCH_LIMIT = 3;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit flop chain with synchronous active-low reset.
// Both monitor inputs use the same depth so their aligned values line up.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/jkff_divergence_monitor.sv
// Aligns the synchronous and asynchronous JK outputs, counts their transitions
// and raises a sticky alarm when they disagree for MISMATCH_LIMIT cycles.
module jkff_divergence_monitor #(
  parameter int CNT_W          = jkff_mon_pkg::DEF_CNT_W,
  parameter int SYNC_STAGES    = 2,
  parameter int MISMATCH_LIMIT = jkff_mon_pkg::DEF_MISMATCH_LIMIT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Q_sync,
  input  logic             Q_async,
  input  logic             CLEAR,
  output logic [CNT_W-1:0] EDGE_CNT_SYNC,
  output logic [CNT_W-1:0] EDGE_CNT_ASYNC,
  output logic             MISMATCH,
  output logic             ALARM,
  output logic [1:0]       STATE
);

  import jkff_mon_pkg::*;

  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MISMATCH_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic a_sync;
  logic a_async;
  logic hist_sync_q;
  logic hist_async_q;
  logic tr_sync;
  logic tr_async;
  logic diff;

  logic [CNT_W-1:0] cnt_sync_q;
  logic [CNT_W-1:0] cnt_sync_d;
  logic [CNT_W-1:0] cnt_async_q;
  logic [CNT_W-1:0] cnt_async_d;
  logic             mismatch_q;
  logic [RUN_W-1:0] run_q;
  mon_state_e       state_q;
  logic             alarm_q;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_q (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .d_i    (Q_sync),
    .q_o    (a_sync)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_async_q (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .d_i    (Q_async),
    .q_o    (a_async)
  );

  assign tr_sync  = a_sync  ^ hist_sync_q;
  assign tr_async = a_async ^ hist_async_q;
  assign diff     = a_sync  ^ a_async;

  // CLEAR wins over a same-cycle transition; counters stick at all-ones.
  always_comb begin
    cnt_sync_d  = cnt_sync_q;
    cnt_async_d = cnt_async_q;
    if (CLEAR) begin
      cnt_sync_d  = '0;
      cnt_async_d = '0;
    end else begin
      if (tr_sync && (cnt_sync_q != CNT_MAX)) begin
        cnt_sync_d = cnt_sync_q + CNT_W'(1);
      end
      if (tr_async && (cnt_async_q != CNT_MAX)) begin
        cnt_async_d = cnt_async_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hist_sync_q  <= 1'b0;
      hist_async_q <= 1'b0;
      cnt_sync_q   <= '0;
      cnt_async_q  <= '0;
      mismatch_q   <= 1'b0;
    end else begin
      hist_sync_q  <= a_sync;
      hist_async_q <= a_async;
      cnt_sync_q   <= cnt_sync_d;
      cnt_async_q  <= cnt_async_d;
      mismatch_q   <= diff;
    end
  end

  // Run length and state advance together; ALARM is registered from the next state.
  always_ff @(posedge CLK) begin
    if (!RESET || CLEAR) begin
      run_q   <= '0;
      state_q <= ST_MATCH;
      alarm_q <= 1'b0;
    end else begin
      if (!diff) begin
        run_q <= '0;
      end else if (run_q != RUN_LIMIT) begin
        run_q <= run_q + RUN_W'(1);
      end

      case (state_q)
        ST_MATCH: begin
          if (diff && (MISMATCH_LIMIT == 1)) begin
            state_q <= ST_ALARM;
            alarm_q <= 1'b1;
          end else if (diff) begin
            state_q <= ST_SUSPECT;
            alarm_q <= 1'b0;
          end else begin
            state_q <= ST_MATCH;
            alarm_q <= 1'b0;
          end
        end
        ST_SUSPECT: begin
          if (!diff) begin
            state_q <= ST_MATCH;
            alarm_q <= 1'b0;
          end else if ((run_q + RUN_W'(1)) == RUN_LIMIT) begin
            state_q <= ST_ALARM;
            alarm_q <= 1'b1;
          end else begin
            state_q <= ST_SUSPECT;
            alarm_q <= 1'b0;
          end
        end
        ST_ALARM: begin
          state_q <= ST_ALARM;
          alarm_q <= 1'b1;
        end
        default: begin
          state_q <= ST_MATCH;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign EDGE_CNT_SYNC  = cnt_sync_q;
  assign EDGE_CNT_ASYNC = cnt_async_q;
  assign MISMATCH       = mismatch_q;
  assign ALARM          = alarm_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_jkff_divergence_monitor.sv
// Scoreboard bench for jkff_divergence_monitor: a delay-line reference model
// predicts each cycle's outputs, and a monitor compares them after each edge.
module tb_jkff_divergence_monitor;

  localparam int CNT_W  = 4;
  localparam int STAGES = 2;
  localparam int LIMIT  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    int cs;
    int ca;
    int mm;
    int al;
    int st;
  } exp_t;

  logic             CLK;
  logic             RESET;
  logic             Q_sync;
  logic             Q_async;
  logic             CLEAR;
  logic [CNT_W-1:0] EDGE_CNT_SYNC;
  logic [CNT_W-1:0] EDGE_CNT_ASYNC;
  logic             MISMATCH;
  logic             ALARM;
  logic [1:0]       STATE;

  int   assertCount = 0;
  int   failCount   = 0;
  exp_t sbQ[$];
  exp_t monE;

  // Reference model: input samples since reset, newest first.
  int   histS[$];
  int   histA[$];
  int   mCs, mCa, mRun, mAl;
  logic curS, curA;

  jkff_divergence_monitor #(
    .CNT_W          (CNT_W),
    .SYNC_STAGES    (STAGES),
    .MISMATCH_LIMIT (LIMIT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .Q_sync         (Q_sync),
    .Q_async        (Q_async),
    .CLEAR          (CLEAR),
    .EDGE_CNT_SYNC  (EDGE_CNT_SYNC),
    .EDGE_CNT_ASYNC (EDGE_CNT_ASYNC),
    .MISMATCH       (MISMATCH),
    .ALARM          (ALARM),
    .STATE          (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs and pushes the model's prediction for the next edge.
  task automatic applyStimulus(input logic rstn, input logic clr, input logic qs, input logic qa);
    exp_t e;
    int   aS, aA, hS, hA, d;
    @(negedge CLK);
    RESET   = rstn;
    CLEAR   = clr;
    Q_sync  = qs;
    Q_async = qa;
    curS    = qs;
    curA    = qa;
    if (!rstn) begin
      histS.delete();
      histA.delete();
      for (int i = 0; i <= STAGES; i++) begin
        histS.push_back(0);
        histA.push_back(0);
      end
      mCs = 0; mCa = 0; mRun = 0; mAl = 0;
      e = '{cs: 0, ca: 0, mm: 0, al: 0, st: 0};
    end else begin
      aS = histS[STAGES-1];
      hS = histS[STAGES];
      aA = histA[STAGES-1];
      hA = histA[STAGES];
      d  = aS ^ aA;
      if (clr) begin
        mCs = 0; mCa = 0; mRun = 0; mAl = 0;
      end else begin
        if (aS != hS) mCs = (mCs < CMAX) ? mCs + 1 : CMAX;
        if (aA != hA) mCa = (mCa < CMAX) ? mCa + 1 : CMAX;
        mRun = d ? ((mRun < LIMIT) ? mRun + 1 : LIMIT) : 0;
        if (mRun == LIMIT) mAl = 1;
      end
      e.cs = mCs;
      e.ca = mCa;
      e.mm = d;
      e.al = mAl;
      e.st = mAl ? 2 : ((mRun > 0) ? 1 : 0);
      histS.push_front(int'(qs));
      void'(histS.pop_back());
      histA.push_front(int'(qa));
      void'(histA.pop_back());
    end
    sbQ.push_back(e);
  endtask

  task automatic holdCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, curS, curA);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  always @(posedge CLK) begin
    #1;
    if (sbQ.size() > 0) begin
      monE = sbQ.pop_front();
      checkOutput("EDGE_CNT_SYNC",  int'(EDGE_CNT_SYNC),  monE.cs);
      checkOutput("EDGE_CNT_ASYNC", int'(EDGE_CNT_ASYNC), monE.ca);
      checkOutput("MISMATCH",       int'(MISMATCH),       monE.mm);
      checkOutput("ALARM",          int'(ALARM),          monE.al);
      checkOutput("STATE",          int'(STATE),          monE.st);
    end
  end

  initial begin
    int   drain;
    int   r;
    logic rs, ra;
    RESET = 1'b0; CLEAR = 1'b0; Q_sync = 1'b1; Q_async = 1'b1;
    curS = 1'b1; curA = 1'b1;

    $display("[TB] reset with both inputs high");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    holdCycles(6);
    settle();
    checkOutput("first_rise_sync", int'(EDGE_CNT_SYNC), 1);

    $display("[TB] lockstep toggling");
    applyStimulus(1'b1, 1'b1, curS, curA);
    for (int t = 0; t < 10; t++) begin
      applyStimulus(1'b1, 1'b0, ~curS, ~curA);
      holdCycles(3);
    end
    holdCycles(2);
    settle();
    checkOutput("lockstep_sync", int'(EDGE_CNT_SYNC), 10);
    checkOutput("lockstep_async", int'(EDGE_CNT_ASYNC), 10);

    $display("[TB] transient mismatch");
    applyStimulus(1'b1, 1'b0, curS, ~curS);
    applyStimulus(1'b1, 1'b0, curS, curA);
    applyStimulus(1'b1, 1'b0, curS, curS);
    holdCycles(6);

    $display("[TB] persistent mismatch then clear");
    applyStimulus(1'b1, 1'b0, curS, ~curS);
    holdCycles(6);
    applyStimulus(1'b1, 1'b0, curS, curS);
    holdCycles(4);
    settle();
    checkOutput("alarm_sticky", int'(ALARM), 1);
    applyStimulus(1'b1, 1'b1, curS, curA);
    holdCycles(3);

    $display("[TB] saturation and clear priority");
    for (int t = 0; t < 20; t++) begin
      applyStimulus(1'b1, 1'b0, ~curS, curA);
      holdCycles(1);
    end
    holdCycles(STAGES + 1);
    settle();
    checkOutput("saturated_sync", int'(EDGE_CNT_SYNC), CMAX);
    applyStimulus(1'b1, 1'b1, curS, curA);
    applyStimulus(1'b1, 1'b0, ~curS, curA);
    for (int i = 1; i < STAGES; i++) applyStimulus(1'b1, 1'b0, curS, curA);
    applyStimulus(1'b1, 1'b1, curS, curA);
    settle();
    checkOutput("clear_beats_edge", int'(EDGE_CNT_SYNC), 0);

    $display("[TB] reset during alarm");
    applyStimulus(1'b1, 1'b0, curS, ~curS);
    holdCycles(STAGES + LIMIT + 2);
    applyStimulus(1'b0, 1'b0, curS, curA);
    settle();
    checkOutput("reset_alarm", int'(ALARM), 0);
    checkOutput("reset_state", int'(STATE), 0);

    $display("[TB] randomized traffic");
    rs = curS;
    ra = curA;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) rs = ~rs;
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      applyStimulus((r != 0), (r >= 1 && r <= 4), rs, ra);
    end

    drain = 0;
    while (sbQ.size() > 0 && drain < 10) begin
      @(negedge CLK);
      drain++;
    end
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/jkff_divergence_monitor.md
# jkff_divergence_monitor

Downstream consumer of the joint JK flip-flop stage. It takes the two flip-flop outputs (`Q_sync`, `Q_async`) and aligns both into the `CLK` domain through matched flop chains. It counts output transitions on each path and raises a sticky alarm when the two paths disagree for a configurable number of consecutive cycles. It is the check stage that tells the bench, or a status register, whether the synchronous and asynchronous JK implementations track each other.

## Interface
Parameters:
- `CNT_W`, 8: width of each transition counter.
- `SYNC_STAGES`, 2: flop-chain depth applied to each input. Minimum 2.
- `MISMATCH_LIMIT`, 3: consecutive mismatch cycles needed to raise `ALARM`. Range 1..255.

Ports:
- `CLK`, in, 1: sole clock, rising edge.
- `RESET`, in, 1: synchronous, active-low reset.
- `Q_sync`, in, 1: output of the synchronous JK flip-flop.
- `Q_async`, in, 1: output of the asynchronous JK flip-flop.
- `CLEAR`, in, 1: synchronous clear of counters, run length and alarm.
- `EDGE_CNT_SYNC`, out, `CNT_W`: saturating count of `Q_sync` transitions.
- `EDGE_CNT_ASYNC`, out, `CNT_W`: saturating count of `Q_async` transitions.
- `MISMATCH`, out, 1: registered; the aligned inputs differ.
- `ALARM`, out, 1: sticky divergence flag.
- `STATE`, out, 2: FSM state encoding.

## Operation
- **Input alignment.** Each input passes through its own `SYNC_STAGES` flop chain. Both chains have equal depth, so the aligned values are compared like-for-like. Chain outputs are `a_sync` and `a_async`.
- **Edge detection.** A one-flop history is kept per path. A transition is `a_x` differing from its history flop.
- **Counters.** Each counter adds 1 per transition. Each saturates at 2^`CNT_W`−1 and never wraps.
- **Mismatch.** `d = a_sync ^ a_async`. `MISMATCH` registers `d`.
- **Run length.** An 8-bit `run` register holds the count of consecutive cycles with `d`=1.
  - `run` increments while `d`=1, saturating at `MISMATCH_LIMIT`.
  - `run` is zeroed on any cycle with `d`=0.
- **FSM states:** MATCH=0, SUSPECT=1, ALARM=2.
  - MATCH → SUSPECT when `d`=1 and `MISMATCH_LIMIT`>1.
  - MATCH → ALARM when `d`=1 and `MISMATCH_LIMIT`=1.
  - SUSPECT → MATCH when `d`=0.
  - SUSPECT → ALARM when `d`=1 and run+1 = `MISMATCH_LIMIT`.
  - ALARM holds until `CLEAR`, even if `d` returns to 0.
  - `ALARM` output = (state == ALARM), registered.
- **CLEAR.** Has priority over all updates in its cycle:
  - Both counters go to 0, and a transition in that same cycle is not counted.
  - `run` goes to 0 and the state goes to MATCH.
  - `MISMATCH` still registers `d`.
  - The flop chains and history flops are not affected.
- **RESET=0.** Zeroes every flop: chains, history flops, counters, `run`, state, `MISMATCH`, `ALARM`. RESET has priority over `CLEAR`.
- **Reset mid-operation.** Behaviour is identical to reset at power-up.
- **Reset values:** `EDGE_CNT_SYNC`=0, `EDGE_CNT_ASYNC`=0, `MISMATCH`=0, `ALARM`=0, `STATE`=0.

## Timing
- An input change that is stable before edge n appears on `a_x` after edge n+`SYNC_STAGES`−1.
- The counter increment and `MISMATCH` are visible after edge n+`SYNC_STAGES`.
- If `MISMATCH` first rises after edge m and the mismatch persists, `ALARM` rises after edge m+`MISMATCH_LIMIT`−1. With `MISMATCH_LIMIT`=1, `ALARM` rises with `MISMATCH`.
- `CLEAR` sampled at edge k gives counters=0, `ALARM`=0 and `STATE`=MATCH after edge k.
- If `d` is still 1 after a clear, `run` restarts from 1 at edge k+1.
- Simultaneous transitions on both paths: both counters increment in the same cycle and `d` is unaffected.
- There are no combinational paths from input to output.

## Structure
- Package `jkff_mon_pkg` holds:
  - the state typedef (MATCH, SUSPECT, ALARM);
  - the run-counter width constant (8);
  - the default `CNT_W` and `MISMATCH_LIMIT`.
- Sub-module `bit_sync`: a parameterised N-stage single-bit flop chain with synchronous active-low reset. It is instantiated twice, once per input.
- Edge detection, counters, run logic and the FSM stay in the top module.

## Test plan
- **Reset.** Hold RESET=0 for 3 cycles with both inputs at 1 → all outputs 0. After release, `MISMATCH` stays 0 and counters show 0 until the aligned history settles; the first aligned 0→1 counts as one transition on each path.
- **Lockstep toggling.** Toggle both inputs together 10 times at 4-cycle spacing → both counters read 10 (`SYNC_STAGES`+1 cycles after the last toggle), `MISMATCH` never 1, `STATE`=0.
- **Transient mismatch.** With `MISMATCH_LIMIT`=3, drive `Q_async`≠`Q_sync` for exactly 2 cycles → `MISMATCH` high for 2 cycles, `STATE` goes 1 then 0, `ALARM` stays 0.
- **Persistent mismatch and clear.** Persistent mismatch → `ALARM`=1 two cycles after `MISMATCH` rises, and stays 1 after the inputs re-agree. Pulse `CLEAR` → counters 0, `ALARM` 0, `STATE` 0 on the next cycle.
- **Saturation and clear priority.** Set `CNT_W`=4 and toggle `Q_sync` 20 times → `EDGE_CNT_SYNC`=15. Assert `CLEAR` in the same cycle as a transition → the counter reads 0.
- **Reset mid-alarm.** Assert RESET=0 for 1 cycle while in ALARM → all outputs 0 on the next cycle and `STATE`=0.
